// File: rtl/sigmoid_pkg.sv
// Shared types for the sigmoid datapath and its on-chip stream checker.
package sigmoid_pkg;

   localparam int DATA_W = 16;
   localparam int CNT_W  = 32;

   typedef logic [DATA_W-1:0] sig_word_t;

   typedef struct packed {
      logic [CNT_W-1:0] total_cnt;
      logic [CNT_W-1:0] fail_cnt;
      logic             first_fail_valid;
      sig_word_t        first_fail_got;
      sig_word_t        first_fail_exp;
      logic             underflow_err;
      logic             overflow_err;
   } chk_status_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO; pointers carry an extra wrap bit so full/empty
// fall out of a plain compare. Head is read asynchronously for same-cycle pops.
module sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   localparam logic [AW:0] PTR_ONE = 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_reg;
   logic [AW:0]      rd_ptr_reg;
   logic [AW:0]      wr_ptr_next;
   logic [AW:0]      rd_ptr_next;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr_reg == rd_ptr_reg);
   assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign count   = wr_ptr_reg - rd_ptr_reg;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr_reg[AW-1:0]];

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      if (do_push) wr_ptr_next = wr_ptr_reg + PTR_ONE;
      if (do_pop)  rd_ptr_next = rd_ptr_reg + PTR_ONE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
      end
   end

   // Storage carries no reset so it maps onto distributed RAM.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg[AW-1:0]] <= din;
   end

endmodule

// File: rtl/sigmoid_stream_checker.sv
// Self-check sink: queues expected sigmoid results and compares them, in order,
// against the live result stream, keeping saturating pass/fail statistics.
module sigmoid_stream_checker #(
   parameter int          DATA_W = 16,
   parameter int          DEPTH  = 16,
   parameter int unsigned TOL    = 0,
   parameter int          CNT_W  = 32,
   localparam int         AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              exp_valid,
   input  logic [DATA_W-1:0] exp_data,
   output logic              exp_ready,
   input  logic              res_valid,
   input  logic [DATA_W-1:0] res_data,
   output logic [CNT_W-1:0]  total_cnt,
   output logic [CNT_W-1:0]  fail_cnt,
   output logic              first_fail_valid,
   output logic [DATA_W-1:0] first_fail_got,
   output logic [DATA_W-1:0] first_fail_exp,
   output logic              underflow_err,
   output logic              overflow_err,
   output logic [AW:0]       pending,
   output logic              idle
);

   import sigmoid_pkg::*;

   localparam logic [CNT_W-1:0] CNT_ONE = 1;
   localparam logic [DATA_W:0]  TOL_V   = (DATA_W+1)'(TOL);

   logic [DATA_W-1:0] fifo_head;
   logic              fifo_full;
   logic              fifo_empty;
   logic              pop_ok;

   sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (DEPTH)
   ) u_exp_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (exp_valid),
      .din   (exp_data),
      .pop   (res_valid),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (pending)
   );

   assign exp_ready = !fifo_full;
   assign pop_ok    = res_valid && !fifo_empty;

   // Stage 1: pair each result with the FIFO head.
   logic              s1_v_reg;
   logic [DATA_W-1:0] s1_got_reg;
   logic [DATA_W-1:0] s1_exp_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v_reg   <= 1'b0;
         s1_got_reg <= '0;
         s1_exp_reg <= '0;
      end else begin
         s1_v_reg <= pop_ok;
         if (pop_ok) begin
            s1_got_reg <= res_data;
            s1_exp_reg <= fifo_head;
         end
      end
   end

   // Stage 2: absolute difference from both subtraction orders, pick the non-negative one.
   logic [DATA_W:0] diff_ge;
   logic [DATA_W:0] diff_lt;
   logic [DATA_W:0] abs_diff;
   logic            mismatch;

   assign diff_ge  = {1'b0, s1_got_reg} - {1'b0, s1_exp_reg};
   assign diff_lt  = {1'b0, s1_exp_reg} - {1'b0, s1_got_reg};
   assign abs_diff = diff_ge[DATA_W] ? diff_lt : diff_ge;
   assign mismatch = (abs_diff > TOL_V);

   logic [CNT_W-1:0]  total_cnt_reg,  total_cnt_next;
   logic [CNT_W-1:0]  fail_cnt_reg,   fail_cnt_next;
   logic              ff_valid_reg,   ff_valid_next;
   logic [DATA_W-1:0] ff_got_reg,     ff_got_next;
   logic [DATA_W-1:0] ff_exp_reg,     ff_exp_next;
   logic              underflow_reg,  underflow_next;
   logic              overflow_reg,   overflow_next;

   always_comb begin
      total_cnt_next = total_cnt_reg;
      fail_cnt_next  = fail_cnt_reg;
      ff_valid_next  = ff_valid_reg;
      ff_got_next    = ff_got_reg;
      ff_exp_next    = ff_exp_reg;
      underflow_next = underflow_reg;
      overflow_next  = overflow_reg;
      if (clear) begin
         // Any stage-2 result landing this cycle is intentionally dropped.
         total_cnt_next = '0;
         fail_cnt_next  = '0;
         ff_valid_next  = 1'b0;
         ff_got_next    = '0;
         ff_exp_next    = '0;
         underflow_next = 1'b0;
         overflow_next  = 1'b0;
      end else begin
         if (s1_v_reg) begin
            if (total_cnt_reg != '1) total_cnt_next = total_cnt_reg + CNT_ONE;
            if (mismatch) begin
               if (fail_cnt_reg != '1) fail_cnt_next = fail_cnt_reg + CNT_ONE;
               if (!ff_valid_reg) begin
                  ff_valid_next = 1'b1;
                  ff_got_next   = s1_got_reg;
                  ff_exp_next   = s1_exp_reg;
               end
            end
         end
         if (res_valid && fifo_empty) underflow_next = 1'b1;
         if (exp_valid && fifo_full)  overflow_next  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         total_cnt_reg <= '0;
         fail_cnt_reg  <= '0;
         ff_valid_reg  <= 1'b0;
         ff_got_reg    <= '0;
         ff_exp_reg    <= '0;
         underflow_reg <= 1'b0;
         overflow_reg  <= 1'b0;
      end else begin
         total_cnt_reg <= total_cnt_next;
         fail_cnt_reg  <= fail_cnt_next;
         ff_valid_reg  <= ff_valid_next;
         ff_got_reg    <= ff_got_next;
         ff_exp_reg    <= ff_exp_next;
         underflow_reg <= underflow_next;
         overflow_reg  <= overflow_next;
      end
   end

   assign total_cnt        = total_cnt_reg;
   assign fail_cnt         = fail_cnt_reg;
   assign first_fail_valid = ff_valid_reg;
   assign first_fail_got   = ff_got_reg;
   assign first_fail_exp   = ff_exp_reg;
   assign underflow_err    = underflow_reg;
   assign overflow_err     = overflow_reg;
   assign idle             = fifo_empty && !s1_v_reg;

endmodule

// File: tb/tb_sigmoid_stream_checker.sv
// Directed bench: three checker instances (exact, TOL=4, 4-bit counters) share one stimulus stream.
module tb_sigmoid_stream_checker;

   import sigmoid_pkg::*;

   logic      clk = 1'b0;
   logic      rst = 1'b1;
   logic      clear = 1'b0;
   logic      exp_valid = 1'b0;
   sig_word_t exp_data = '0;
   logic      res_valid = 1'b0;
   sig_word_t res_data = '0;

   always #5 clk = ~clk;

   logic        exp_ready, ffv, udf, ovf, idle;
   logic [31:0] total, fails;
   sig_word_t   ff_got, ff_exp;
   logic [4:0]  pending;

   logic        t_ready, t_ffv, t_udf, t_ovf, t_idle;
   logic [31:0] t_total, t_fails;
   sig_word_t   t_got, t_exp;
   logic [4:0]  t_pending;

   logic        s_ready, s_ffv, s_udf, s_ovf, s_idle;
   logic [3:0]  s_total, s_fails;
   sig_word_t   s_got, s_exp;
   logic [4:0]  s_pending;

   sigmoid_stream_checker dut (
      .clk(clk), .rst(rst), .clear(clear), .exp_valid(exp_valid), .exp_data(exp_data),
      .exp_ready(exp_ready), .res_valid(res_valid), .res_data(res_data),
      .total_cnt(total), .fail_cnt(fails), .first_fail_valid(ffv),
      .first_fail_got(ff_got), .first_fail_exp(ff_exp), .underflow_err(udf),
      .overflow_err(ovf), .pending(pending), .idle(idle)
   );

   sigmoid_stream_checker #(.TOL(4)) dut_tol (
      .clk(clk), .rst(rst), .clear(clear), .exp_valid(exp_valid), .exp_data(exp_data),
      .exp_ready(t_ready), .res_valid(res_valid), .res_data(res_data),
      .total_cnt(t_total), .fail_cnt(t_fails), .first_fail_valid(t_ffv),
      .first_fail_got(t_got), .first_fail_exp(t_exp), .underflow_err(t_udf),
      .overflow_err(t_ovf), .pending(t_pending), .idle(t_idle)
   );

   sigmoid_stream_checker #(.CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .clear(clear), .exp_valid(exp_valid), .exp_data(exp_data),
      .exp_ready(s_ready), .res_valid(res_valid), .res_data(res_data),
      .total_cnt(s_total), .fail_cnt(s_fails), .first_fail_valid(s_ffv),
      .first_fail_got(s_got), .first_fail_exp(s_exp), .underflow_err(s_udf),
      .overflow_err(s_ovf), .pending(s_pending), .idle(s_idle)
   );

   int n_vec  = 0;
   int n_miss = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s = 0x%0h", tag, got);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; exp_valid = 1'b0; res_valid = 1'b0; clear = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic push(input sig_word_t v);
      exp_valid = 1'b1; exp_data = v;
      tick();
      exp_valid = 1'b0;
   endtask

   task automatic result(input sig_word_t v);
      res_valid = 1'b1; res_data = v;
      tick();
      res_valid = 1'b0;
   endtask

   sig_word_t vec4 [4] = '{16'h0800, 16'h0A00, 16'h0C00, 16'h0FFF};

   initial begin
      tick(2);
      rst = 1'b0;
      // reset state
      check("rst exp_ready", exp_ready, 1);
      check("rst idle", idle, 1);
      check("rst total", total, 0);
      check("rst fail", fails, 0);
      check("rst pending", pending, 0);
      check("rst flags", {ffv, udf, ovf}, 0);

      // exact match
      for (int i = 0; i < 4; i++) push(vec4[i]);
      check("match pending", pending, 4);
      tick(5);
      for (int i = 0; i < 4; i++) result(vec4[i]);
      check("match idle busy", idle, 0);
      tick();
      check("match total", total, 4);
      check("match fail", fails, 0);
      check("match idle", idle, 1);
      check("match pending0", pending, 0);

      // mismatch capture, exact and TOL=4
      do_reset();
      push(16'h0800); push(16'h0900);
      result(16'h0801); result(16'h0905);
      tick(2);
      check("mis total", total, 2);
      check("mis fail", fails, 2);
      check("mis ffv", ffv, 1);
      check("mis ff_got", ff_got, 16'h0801);
      check("mis ff_exp", ff_exp, 16'h0800);
      check("tol fail", t_fails, 1);
      check("tol ff_got", t_got, 16'h0905);
      check("tol ff_exp", t_exp, 16'h0900);

      // full / overflow
      do_reset();
      for (int i = 0; i < 16; i++) push(16'(i * 16'h0101 + 1));
      check("full ready", exp_ready, 0);
      check("full pending", pending, 16);
      check("full ovf pre", ovf, 0);
      push(16'hDEAD);
      check("full ovf", ovf, 1);
      check("full pending17", pending, 16);
      for (int i = 0; i < 16; i++) result(16'(i * 16'h0101 + 1));
      tick(2);
      check("full total", total, 16);
      check("full fail", fails, 0);
      check("full drain", pending, 0);
      check("full ready1", exp_ready, 1);

      // underflow with a push in the same cycle
      do_reset();
      exp_valid = 1'b1; exp_data = 16'h1234; res_valid = 1'b1; res_data = 16'h1234;
      tick();
      exp_valid = 1'b0; res_valid = 1'b0;
      check("udf flag", udf, 1);
      check("udf pending", pending, 1);
      tick(2);
      check("udf total", total, 0);
      check("udf fail", fails, 0);

      // streaming, 5-cycle offset
      do_reset();
      for (int c = 0; c < 69; c++) begin
         exp_valid = (c < 64);
         exp_data  = 16'(16'h1000 + c * 37);
         res_valid = (c >= 5);
         res_data  = 16'(16'h1000 + (c - 5) * 37);
         tick();
      end
      exp_valid = 1'b0; res_valid = 1'b0;
      tick(2);
      check("stream total", total, 64);
      check("stream fail", fails, 0);
      check("stream errs", {udf, ovf}, 0);
      check("stream pending", pending, 0);

      // reset in the middle of a stream
      for (int c = 0; c < 8; c++) begin
         exp_valid = 1'b1; exp_data = 16'(c);
         res_valid = (c >= 3); res_data = 16'(c + 7 - 3);
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0; exp_valid = 1'b0; res_valid = 1'b0;
      check("mrst total", total, 0);
      check("mrst fail", fails, 0);
      check("mrst pending", pending, 0);
      check("mrst idle", idle, 1);
      check("mrst ready", exp_ready, 1);
      check("mrst ffv", ffv, 0);
      tick(2);
      check("mrst inflight", total, 0);

      // saturation and clear
      do_reset();
      for (int i = 0; i < 20; i++) begin
         push(16'(i));
         result(16'(i + 1));
      end
      tick(2);
      check("sat fail", s_fails, 15);
      check("sat total", s_total, 15);
      check("wide fail", fails, 20);
      check("wide ff_got", ff_got, 1);
      check("tol total", t_total, 20);
      check("tol fail0", t_fails, 0);
      result(16'h0055);
      push(16'h0A); push(16'h0B); push(16'h0C);
      check("pre-clr udf", udf, 1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("clr fail", s_fails, 0);
      check("clr total", s_total, 0);
      check("clr ffv", ffv, 0);
      check("clr udf", udf, 0);
      check("clr pending", pending, 3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
